// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the configurable UART receiver.
// Holds the receive FSM state enum, the parity-mode encodings and the
// oversample clock-divider computation used to size the tick generator.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    // 00 and 11 both mean "no parity"; only these two codes enable it
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Clocks per oversample tick, rounded to nearest
    function automatic int calcDiv(input int clkFreq, input int baud, input int os);
        longint d = longint'(baud) * longint'(os);
        return int'((longint'(clkFreq) + d / 2) / d);
    endfunction

endpackage

// File: rtl/uart_os_tickgen.sv
// uart_os_tickgen: free-running divide-by-DIV oversample tick generator.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the divider
//   tick - high for one clock every DIV clocks
module uart_os_tickgen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = cnt == W'(DIV - 1);

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_receiver_cfg.sv
// uart_receiver_cfg: oversampling UART receiver with per-frame configuration.
// Build option: define UART_RX_PARITY_EN to compile in even/odd parity
// checking; without it cfg_parity is ignored and rx_parity_err is 0.
// Ports:
//   clk, rst         - clock (rising edge) and synchronous active-high reset
//   rxd              - asynchronous serial input, idle high
//   cfg_data_bits    - data bits per frame (5..9, clamped), latched at start bit
//   cfg_parity       - 00/11 none, 01 even, 10 odd, latched at start bit
//   cfg_stop2        - two stop bits when 1, latched at start bit
//   rx_valid/rx_ready- held-word handshake
//   rx_data          - received word, right-aligned, upper bits zero
//   rx_frame_err     - a stop bit of the held word was low
//   rx_parity_err    - parity of the held word was wrong
//   overrun          - one-cycle pulse when a finished frame is dropped
//   break_det        - one-cycle pulse on a break frame
//   rx_idle          - FSM is in IDLE
module uart_receiver_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [3:0] cfg_data_bits,
    input  logic [1:0] cfg_parity,
    input  logic       cfg_stop2,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [8:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       overrun,
    output logic       break_det,
    output logic       rx_idle
);
    localparam int DIV = calcDiv(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    state_t state, nextState;
    logic [1:0] sync;
    logic rxS, rxPrev, tick, sample, start, done, load, brk;
    logic [CW-1:0] osCnt;
    logic [3:0] bitCnt, nBits;
    logic [8:0] shReg;
    logic stop2, frameErr, inBreak, parOn, parBit;

    uart_os_tickgen #(.DIV(DIV)) tickGen (.clk(clk), .rst(rst), .tick(tick));

    assign rxS     = sync[1];
    assign start   = state == IDLE && rxPrev && !rxS;
    assign sample  = tick && osCnt == LAST;
    assign load    = done && (!rx_valid || rx_ready);
    assign rx_idle = state == IDLE;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nextState;
    end

    always_comb begin
        nextState = state;
        done = 1'b0;
        brk = 1'b0;
        case (state)
            IDLE:   nextState = start ? START : IDLE;
            START:  if (tick && osCnt == HALF) nextState = rxS ? IDLE : DATA;
            DATA:   if (sample && bitCnt == nBits - 4'd1) nextState = parOn ? PARITY : STOP1;
            PARITY: if (sample) nextState = STOP1;
            // after a break, park here until the line returns high
            STOP1:  if (inBreak) nextState = rxS ? IDLE : STOP1;
                    else if (sample) begin
                        brk = !rxS && shReg == '0 && !parBit;
                        done = !brk && !stop2;
                        nextState = brk ? STOP1 : stop2 ? STOP2 : IDLE;
                    end
            STOP2:  if (sample) begin
                        done = 1'b1;
                        nextState = IDLE;
                    end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            rxPrev <= 1'b1;
            osCnt <= '0;
            bitCnt <= '0;
            nBits <= '0;
            shReg <= '0;
            stop2 <= 1'b0;
            frameErr <= 1'b0;
            inBreak <= 1'b0;
            rx_valid <= 1'b0;
            rx_data <= '0;
            rx_frame_err <= 1'b0;
            overrun <= 1'b0;
            break_det <= 1'b0;
        end else begin
            sync <= {sync[0], rxd};
            rxPrev <= rxS;
            overrun <= done && rx_valid && !rx_ready;
            break_det <= brk;
            if (start) begin
                osCnt <= '0;
                bitCnt <= '0;
                shReg <= '0;
                frameErr <= 1'b0;
                inBreak <= 1'b0;
                nBits <= cfg_data_bits < 4'd5 ? 4'd5 : cfg_data_bits > 4'd9 ? 4'd9 : cfg_data_bits;
                stop2 <= cfg_stop2;
            end else if (tick)
                // the start-bit midpoint re-phases the counter to bit centres
                osCnt <= (state == START && osCnt == HALF) || osCnt == LAST ? '0 : osCnt + 1'b1;
            if (state == DATA && sample) begin
                shReg[bitCnt] <= rxS;
                bitCnt <= bitCnt + 1'b1;
            end
            if ((state == STOP1 || state == STOP2) && sample && !rxS) frameErr <= 1'b1;
            if (brk) inBreak <= 1'b1;
            if (load) begin
                rx_data <= shReg;
                rx_frame_err <= frameErr || !rxS;
            end
            rx_valid <= load || (rx_valid && !rx_ready);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic [1:0] parMode;
    logic parErr;

    assign parOn = parMode == PAR_EVEN || parMode == PAR_ODD;

    always_ff @(posedge clk) begin
        if (rst) begin
            parMode <= '0;
            parBit <= 1'b0;
            parErr <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            if (start) begin
                parMode <= cfg_parity;
                parBit <= 1'b0;
                parErr <= 1'b0;
            end else if (state == PARITY && sample) begin
                parBit <= rxS;
                parErr <= ^shReg ^ rxS ^ (parMode == PAR_ODD);
            end
            if (load) rx_parity_err <= parErr;
        end
    end
`else
    // cfg_parity has no function without parity support
    logic unusedPar;

    assign unusedPar = cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD;
    assign parOn = 1'b0;
    assign parBit = 1'b0;
    assign rx_parity_err = 1'b0;
`endif
endmodule
